// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller.
//   fn_t          : R-type function codes understood by the ALU (instr [5:0])
//   OPC_*         : opcodes (instr [31:26]) the controller recognises
//   ctrl_state_t  : controller FSM states
//   is_supported  : screens an opcode/function pair against the set whose
//                   results may be returned to a requester
package alu_pkg;

  typedef enum logic [5:0] {
    FN_SLL  = 6'b000000,
    FN_SRL  = 6'b000010,
    FN_SRA  = 6'b000011,
    FN_SLLV = 6'b000100,
    FN_SRLV = 6'b000110,
    FN_SRAV = 6'b000111,
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110,
    FN_SLTU = 6'b101011
  } fn_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } ctrl_state_t;

  // Shifts are implemented by the ALU but deliberately not exposed here.
  function automatic logic is_supported(input logic [5:0] opc, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    if (opc == OPC_ADDIU) begin
      ok = 1'b1;
    end else if (opc == OPC_RTYPE) begin
      case (fn)
        FN_ADDU, FN_SUBU, FN_SLTU, FN_AND, FN_OR, FN_XOR: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit integer ALU.
//   a, b : operands (b already sign-extended for immediates)
//   fn   : function code, used when opc is R-type
//   opc  : opcode
//   r    : result, modulo 2^32; 0 for codes it does not implement
// Shift amounts come from a[4:0].
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  fn,
  input  logic [5:0]  opc,
  output logic [31:0] r
);

  always_comb begin
    r = '0;
    if (opc == OPC_ADDIU) begin
      r = a + b;
    end else if (opc == OPC_RTYPE) begin
      case (fn)
        FN_ADDU:          r = a + b;
        FN_SUBU:          r = a - b;
        FN_SLTU:          r = {31'd0, (a < b)};
        FN_AND:           r = a & b;
        FN_OR:            r = a | b;
        FN_XOR:           r = a ^ b;
        FN_SRA, FN_SRAV:  r = $unsigned($signed(b) >>> a[4:0]);
        FN_SLL, FN_SLLV:  r = b << a[4:0];
        FN_SRL, FN_SRLV:  r = b >> a[4:0];
        default:          r = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters (0: execute stage,
// 1: address/branch helper) with round-robin arbitration, one transaction
// in flight.
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid_N/req_ready_N : request handshake per requester
//   req_a_N, req_b_N        : operands
//   req_fn_N, req_opc_N     : function code / opcode
//   resp_valid_N/resp_ready_N : response handshake per requester
//   resp_r_N, resp_err_N    : result, unsupported-operation flag
//   busy                    : a result is being held (RESP)
//   dbg_state, dbg_prio     : FSM state and current tie-break priority
//
// Handshake: a request transfers on a rising edge where req_valid_N and
// req_ready_N are both high; req_ready_N is combinational and only ever
// asserted in IDLE for the granted requester. A response transfers on an
// edge where resp_valid_N and resp_ready_N are both high; resp_valid_N
// stays high and resp_r_N/resp_err_N stay stable until then.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [5:0]       req_fn_0,
  input  logic [5:0]       req_opc_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [5:0]       req_fn_1,
  input  logic [5:0]       req_opc_1,
  output logic             resp_valid_0,
  input  logic             resp_ready_0,
  output logic [WIDTH-1:0] resp_r_0,
  output logic             resp_err_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_r_1,
  output logic             resp_err_1,
  output logic             busy,
  output ctrl_state_t      dbg_state,
  output logic             dbg_prio
);

  ctrl_state_t      state_q, state_d;
  logic             prio_q, prio_d;
  logic             own_q, own_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic             grant_any;
  logic             grant;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [5:0]       alu_fn, alu_opc;
  logic             alu_ok;

  // Arbitration and ALU operand mux. Operands are zeroed when nothing is
  // granted so the shared ALU does not toggle on idle requester buses.
  always_comb begin
    grant_any = 1'b0;
    grant     = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_fn    = '0;
    alu_opc   = '0;
    if (state_q == IDLE) begin
      grant_any = req_valid_0 | req_valid_1;
      // Tie goes to prio; otherwise the single valid requester wins.
      grant     = (req_valid_0 & req_valid_1) ? prio_q : req_valid_1;
    end
    if (grant_any) begin
      alu_a   = grant ? req_a_1   : req_a_0;
      alu_b   = grant ? req_b_1   : req_b_0;
      alu_fn  = grant ? req_fn_1  : req_fn_0;
      alu_opc = grant ? req_opc_1 : req_opc_0;
    end
  end

  ALU u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .fn  (alu_fn),
    .opc (alu_opc),
    .r   (alu_r)
  );

  assign alu_ok = is_supported(alu_opc, alu_fn);

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    own_d        = own_q;
    res_d        = res_q;
    err_d        = err_q;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    resp_r_0     = '0;
    resp_r_1     = '0;
    resp_err_0   = 1'b0;
    resp_err_1   = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_0 = grant_any & ~grant;
        req_ready_1 = grant_any & grant;
        if (grant_any) begin
          // Unsupported codes never leak the raw ALU output.
          res_d   = alu_ok ? alu_r : '0;
          err_d   = ~alu_ok;
          own_d   = grant;
          state_d = RESP;
        end
      end
      RESP: begin
        busy = 1'b1;
        if (own_q) begin
          resp_valid_1 = 1'b1;
          resp_r_1     = res_q;
          resp_err_1   = err_q;
        end else begin
          resp_valid_0 = 1'b1;
          resp_r_0     = res_q;
          resp_err_0   = err_q;
        end
        // Always return to IDLE for a cycle; the loser of this service
        // wins the next tie.
        if (own_q ? resp_ready_1 : resp_ready_0) begin
          state_d = IDLE;
          prio_d  = ~own_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      own_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      own_q   <= own_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed vectors, a transaction
// level reference model compared every cycle, and literal spot checks.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [5:0]   req_fn_0, req_opc_0, req_fn_1, req_opc_1;
  logic         resp_valid_0, resp_ready_0, resp_err_0;
  logic         resp_valid_1, resp_ready_1, resp_err_1;
  logic [W-1:0] resp_r_0, resp_r_1;
  logic         busy, dbg_prio;
  ctrl_state_t  dbg_state;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_fn_0(req_fn_0), .req_opc_0(req_opc_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_fn_1(req_fn_1), .req_opc_1(req_opc_1),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
    .resp_r_0(resp_r_0), .resp_err_0(resp_err_0),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
    .resp_r_1(resp_r_1), .resp_err_1(resp_err_1),
    .busy(busy), .dbg_state(dbg_state), .dbg_prio(dbg_prio)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {err, result} from the architectural definition of each op.
  function automatic logic [32:0] model_op(input logic [5:0] opc, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
    if (opc == 6'b001001) return {1'b0, a + b};
    if (opc == 6'b000000) begin
      case (fn)
        6'b100001: return {1'b0, a + b};
        6'b100011: return {1'b0, a - b};
        6'b101011: return {1'b0, (a < b) ? 32'd1 : 32'd0};
        6'b100100: return {1'b0, a & b};
        6'b100101: return {1'b0, a | b};
        6'b100110: return {1'b0, a ^ b};
        default: ;
      endcase
    end
    return {1'b1, 32'd0};
  endfunction

  logic         m_busy = 1'b0, m_own = 1'b0, m_prio = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [W+1:0] exp_q[$];     // {owner, err, result}
  int           obs_grants[$]; // grant order as observed on req_ready

  // Compare process: outputs are checked on the falling edge against the
  // model, then the model takes the rising edge that follows using the
  // inputs already on the bus.
  initial begin
    logic         g_any, g, rdy;
    logic [32:0]  o;
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_busy = 1'b0; m_own = 1'b0; m_prio = 1'b0; m_err = 1'b0; m_res = '0;
        exp_q.delete();
      end
      g_any = !m_busy && (req_valid_0 || req_valid_1);
      g     = (req_valid_0 && req_valid_1) ? m_prio : req_valid_1;
      check("req_ready_0", req_ready_0, g_any && !g);
      check("req_ready_1", req_ready_1, g_any && g);
      check("resp_valid_0", resp_valid_0, m_busy && !m_own);
      check("resp_valid_1", resp_valid_1, m_busy && m_own);
      check("resp_r_0", resp_r_0, (m_busy && !m_own) ? m_res : 32'd0);
      check("resp_r_1", resp_r_1, (m_busy && m_own) ? m_res : 32'd0);
      check("resp_err_0", resp_err_0, m_busy && !m_own && m_err);
      check("resp_err_1", resp_err_1, m_busy && m_own && m_err);
      check("busy", busy, m_busy);
      check("state_resp", dbg_state == RESP, m_busy);
      check("prio", dbg_prio, m_prio);
      if (req_ready_0) obs_grants.push_back(0);
      if (req_ready_1) obs_grants.push_back(1);
      if (reset_n) begin
        if (m_busy) begin
          rdy = m_own ? resp_ready_1 : resp_ready_0;
          if (rdy) begin
            if (exp_q.size() == 0) begin
              check("sb_nonempty", 0, 1);
            end else begin
              e = exp_q.pop_front();
              check("sb_resp", {m_own, m_own ? resp_err_1 : resp_err_0,
                                m_own ? resp_r_1 : resp_r_0}, e[31:0] | (32'(e[W+1:W]) << 30 & 32'h0));
              check("sb_owner_err", {e[W+1], e[W]}, {m_own, m_own ? resp_err_1 : resp_err_0});
              check("sb_result", m_own ? resp_r_1 : resp_r_0, e[W-1:0]);
            end
            m_busy = 1'b0;
            m_prio = !m_own;
          end
        end else if (g_any) begin
          o = g ? model_op(req_opc_1, req_fn_1, req_a_1, req_b_1)
                : model_op(req_opc_0, req_fn_0, req_a_0, req_b_0);
          m_err  = o[32];
          m_res  = o[31:0];
          m_own  = g;
          m_busy = 1'b1;
          exp_q.push_back({g, o});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit p, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    if (p) begin
      req_opc_1 = opc; req_fn_1 = fn; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
    end else begin
      req_opc_0 = opc; req_fn_0 = fn; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction with the response consumed immediately.
  task automatic send(input bit p, input logic [5:0] opc, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic exp_err);
    int t;
    if (p) resp_ready_1 = 1'b1; else resp_ready_0 = 1'b1;
    set_req(p, opc, fn, a, b);
    #1;
    t = 0;
    while (!(p ? req_ready_1 : req_ready_0) && t < 10) begin
      tick();
      t++;
    end
    check("accept_timeout", t < 10, 1);
    tick();
    if (p) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
    check("send_valid", p ? resp_valid_1 : resp_valid_0, 1);
    check("send_r", p ? resp_r_1 : resp_r_0, exp_r);
    check("send_err", p ? resp_err_1 : resp_err_0, exp_err);
    tick();
    check("send_idle_after", busy, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    req_valid_0 = 0; req_a_0 = '0; req_b_0 = '0; req_fn_0 = '0; req_opc_0 = '0;
    req_valid_1 = 0; req_a_1 = '0; req_b_1 = '0; req_fn_1 = '0; req_opc_1 = '0;
    resp_ready_0 = 0; resp_ready_1 = 0;

    // Model pinned against hand-computed values.
    check("model_addu",  model_op(6'b000000, 6'b100001, 32'd5, 32'd7), {1'b0, 32'd12});
    check("model_subu",  model_op(6'b000000, 6'b100011, 32'd3, 32'd5), {1'b0, 32'hFFFF_FFFE});
    check("model_sltu",  model_op(6'b000000, 6'b101011, 32'd3, 32'd5), {1'b0, 32'd1});
    check("model_sra",   model_op(6'b000000, 6'b000011, 32'd1, 32'd8), {1'b1, 32'd0});
    check("model_addiu", model_op(6'b001001, 6'b111111, 32'hFFFF_FFFF, 32'd1), {1'b0, 32'd0});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid_0", resp_valid_0, 0);
    check("rst_busy", busy, 0);
    check("rst_prio", dbg_prio, 0);
    check("rst_r_1", resp_r_1, 0);
    reset_n = 1'b1;
    tick();

    // Basic ADDU on port 0.
    send(0, OPC_RTYPE, 6'b100001, 32'd5, 32'd7, 32'd12, 1'b0);

    // Both valid continuously after a fresh reset: grants alternate.
    pulse_reset();
    obs_grants.delete();
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    set_req(0, OPC_RTYPE, 6'b100011, 32'd3, 32'd5);
    set_req(1, OPC_RTYPE, 6'b101011, 32'd3, 32'd5);
    #1;
    check("rr_first_grant0", req_ready_0, 1);
    check("rr_first_not1", req_ready_1, 0);
    tick();
    check("rr_subu", resp_r_0, 32'hFFFF_FFFE);
    tick();
    check("rr_second_grant1", req_ready_1, 1);
    tick();
    check("rr_sltu", resp_r_1, 32'd1);
    repeat (5) tick();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tick();
    check("rr_count", obs_grants.size() >= 4, 1);
    if (obs_grants.size() >= 4) begin
      check("rr_g0", obs_grants[0], 0);
      check("rr_g1", obs_grants[1], 1);
      check("rr_g2", obs_grants[2], 0);
      check("rr_g3", obs_grants[3], 1);
    end
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    tick();

    // Unsupported SRA on port 1, then a normal op.
    send(1, OPC_RTYPE, 6'b000011, 32'd4, 32'h8000_0000, 32'd0, 1'b1);
    send(1, OPC_RTYPE, 6'b100001, 32'd1, 32'd2, 32'd3, 1'b0);

    // ADDIU wraps to 0 with the response held off for 5 cycles.
    resp_ready_0 = 1'b0;
    set_req(0, OPC_ADDIU, 6'b010101, 32'hFFFF_FFFF, 32'd1);
    tick();
    req_valid_0 = 1'b0;
    set_req(1, OPC_RTYPE, 6'b100001, 32'd10, 32'd20);
    resp_ready_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", resp_valid_0, 1);
      check("hold_r", resp_r_0, 32'd0);
      check("hold_ready1", req_ready_1, 0);
      tick();
    end
    resp_ready_0 = 1'b1;
    tick();
    check("after_hold_grant1", req_ready_1, 1);
    tick();
    req_valid_1 = 1'b0;
    check("after_hold_r1", resp_r_1, 32'd30);
    tick();

    // Reset in the middle of RESP, with prio set to 1 beforehand.
    send(0, OPC_RTYPE, 6'b100001, 32'd1, 32'd1, 32'd2, 1'b0);
    check("pre_rst_prio", dbg_prio, 1);
    resp_ready_0 = 1'b0;
    set_req(0, OPC_RTYPE, 6'b100001, 32'd2, 32'd2);
    tick();
    req_valid_0 = 1'b0;
    check("mid_resp_valid", resp_valid_0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid_drop", resp_valid_0, 0);
    check("async_busy_drop", busy, 0);
    tick();
    reset_n = 1'b1;
    check("post_rst_prio", dbg_prio, 0);
    check("post_rst_state", dbg_state == IDLE, 1);
    tick();

    // Logic ops.
    send(0, OPC_RTYPE, 6'b100110, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0);
    send(0, OPC_RTYPE, 6'b100101, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAFAF_AFAF, 1'b0);
    send(0, OPC_RTYPE, 6'b100100, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, 1'b0);

    // Withdrawn request: valid for one idle cycle... dropped before an edge.
    req_valid_1 = 1'b1;
    #2 req_valid_1 = 1'b0;
    tick();
    check("withdraw_idle", busy, 0);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
